fft_input_loader: RTL and testbench

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

---
 rtl/fft_input_loader.sv | 153 +++++++++++++++
 tb/tb_fft_input_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// Frame loader for a streaming FFT: windows incoming real samples and writes them
// to the FFT RAM in bit-reversed order, then hands the frame to the FFT core.
module fft_input_loader #(
    parameter int unsigned bw_fftp   = 12,
    parameter int unsigned bw_data   = 18,
    parameter int unsigned win_delay = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               In_Valid,
    input  logic [bw_data-1:0] In_Sample,
    output logic               In_Ready,
    output logic [bw_fftp-1:0] WinAddr,
    input  logic [bw_data-1:0] WinCoef,
    output logic [bw_fftp-1:0] WrRAMAddr,
    output logic [bw_data-1:0] Out_Re,
    output logic [bw_data-1:0] Out_Im,
    output logic               WE,
    output logic               FFTStart,
    input  logic               FFTBusy,
    input  logic               FFTEnd,
    output logic               Overrun,
    output logic               Busy
);

    localparam int unsigned PW = 2 * bw_data + 1;
    localparam logic [bw_fftp-1:0] LAST = {bw_fftp{1'b1}};

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, WAIT} state_t;

    state_t             state;
    logic [bw_fftp-1:0] cnt;
    logic               accept;

    logic [win_delay-1:0] dly_v;
    logic [bw_data-1:0]   dly_s [win_delay];
    logic [bw_fftp-1:0]   dly_a [win_delay];

    logic                 prod_v;
    logic signed [PW-1:0] prod;
    logic [bw_fftp-1:0]   prod_a;

    logic                 res_v;
    logic [bw_data-1:0]   res;
    logic [bw_fftp-1:0]   res_a;

    function automatic logic [bw_fftp-1:0] bitrev(input logic [bw_fftp-1:0] a);
        logic [bw_fftp-1:0] r;
        for (int i = 0; i < int'(bw_fftp); i++) begin
            r[i] = a[int'(bw_fftp) - 1 - i];
        end
        return r;
    endfunction

    assign In_Ready = (state == LOAD);
    assign Busy     = (state != IDLE);
    assign WinAddr  = cnt;
    assign accept   = In_Valid && In_Ready;
    assign Out_Im   = '0;
    // The start pulse follows FFTBusy within the cycle so it lands one cycle after the last write.
    assign FFTStart = (state == START) && !FFTBusy;

    // Frame sequencing; the last write is recognised by its all-ones bit-reversed address.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Enable) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (In_Valid) begin
                        if (cnt == LAST) begin
                            state <= FLUSH;
                        end else begin
                            cnt <= cnt + bw_fftp'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (WE && WrRAMAddr == LAST) begin
                        state <= START;
                    end
                end
                START: begin
                    if (!FFTBusy) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (FFTEnd) begin
                        state <= Enable ? LOAD : IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sample delay line matching the window ROM latency, then multiply, scale and write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            dly_v     <= '0;
            for (int i = 0; i < int'(win_delay); i++) begin
                dly_s[i] <= '0;
                dly_a[i] <= '0;
            end
            prod_v    <= 1'b0;
            prod      <= '0;
            prod_a    <= '0;
            res_v     <= 1'b0;
            res       <= '0;
            res_a     <= '0;
            WE        <= 1'b0;
            Out_Re    <= '0;
            WrRAMAddr <= '0;
            Overrun   <= 1'b0;
        end else begin
            dly_v[0] <= accept;
            dly_s[0] <= In_Sample;
            dly_a[0] <= cnt;
            for (int i = 1; i < int'(win_delay); i++) begin
                dly_v[i] <= dly_v[i-1];
                dly_s[i] <= dly_s[i-1];
                dly_a[i] <= dly_a[i-1];
            end

            prod_v <= dly_v[win_delay-1];
            prod   <= PW'($signed(dly_s[win_delay-1])) * PW'($signed({1'b0, WinCoef}));
            prod_a <= dly_a[win_delay-1];

            res_v <= prod_v;
            res   <= bw_data'(prod >>> bw_data);
            res_a <= prod_a;

            WE        <= res_v;
            Out_Re    <= res_v ? res : '0;
            WrRAMAddr <= res_v ? bitrev(res_a) : '0;

            if (In_Valid && !In_Ready && Busy) begin
                Overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader with N=16, an 18-bit window and a 2-cycle ROM model.
module tb_fft_input_loader;

    logic        clk = 1'b0;
    logic        Reset, Enable, In_Valid, FFTBusy, FFTEnd;
    logic [17:0] In_Sample, WinCoef;
    logic        In_Ready, WE, FFTStart, Overrun, Busy;
    logic [3:0]  WinAddr, WrRAMAddr;
    logic [17:0] Out_Re, Out_Im;

    fft_input_loader #(.bw_fftp(4), .bw_data(18), .win_delay(2)) dut (
        .Clock(clk), .Reset(Reset), .Enable(Enable), .In_Valid(In_Valid),
        .In_Sample(In_Sample), .In_Ready(In_Ready), .WinAddr(WinAddr),
        .WinCoef(WinCoef), .WrRAMAddr(WrRAMAddr), .Out_Re(Out_Re), .Out_Im(Out_Im),
        .WE(WE), .FFTStart(FFTStart), .FFTBusy(FFTBusy), .FFTEnd(FFTEnd),
        .Overrun(Overrun), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int re; int im; int raw; int ed;} wr_t;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  zviol = 0;
    bit  rom_mode = 1'b0;
    logic [3:0] rom_a = '0;
    wr_t wq[$];
    int  acc_q[$];
    int  fst_q[$];
    int  samp [16];
    int  exp_re [16];
    int  rev4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int  rnd_s [16] = '{-3, -1, 1, 3, 131071, -131072, 256, -256, 5, -5, 0, 2, -2, 7, -7, 100};
    int  rnd_e [16] = '{-2, -1, 0, 1, 65535, -65536, 128, -128, 2, -3, 0, 1, -1, 3, -4, 50};

    always @(posedge clk) cyc <= cyc + 1;

    // Window ROM: address registered, then data registered (two-cycle latency).
    always @(posedge clk) begin
        rom_a   <= WinAddr;
        WinCoef <= rom_mode ? 18'(int'(rom_a) << 14) : 18'h20000;
    end

    always @(negedge clk) begin
        if (WE) wq.push_back('{int'(WrRAMAddr), int'($signed(Out_Re)), int'($signed(Out_Im)), int'(Out_Re), cyc});
        if (FFTStart) fst_q.push_back(cyc);
        if (!WE && (Out_Re != '0 || Out_Im != '0)) zviol++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        wq.delete();
        acc_q.delete();
        fst_q.delete();
    endtask

    task automatic run_frame(input bit gapped, input int count);
        int sent = 0;
        int guard = 0;
        bit tog = 1'b0;
        while (sent < count && guard < 200) begin
            if (In_Ready && (!gapped || tog)) begin
                In_Valid  = 1'b1;
                In_Sample = 18'(samp[sent]);
                acc_q.push_back(cyc + 1);
                sent++;
            end else begin
                In_Valid = 1'b0;
            end
            tog = !tog;
            step();
            guard++;
        end
        In_Valid = 1'b0;
        if (guard >= 200) check("frame_timeout", sent, count);
    endtask

    task automatic start_frame(input bit gapped);
        clear_log();
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        run_frame(gapped, 16);
        repeat (8) step();
    endtask

    task automatic check_frame(input string nm);
        check({nm, "_count"}, wq.size(), 16);
        for (int j = 0; j < 16 && j < wq.size(); j++) begin
            check($sformatf("%s_addr[%0d]", nm, j), wq[j].addr, rev4[j]);
            check($sformatf("%s_re[%0d]", nm, j), wq[j].re, exp_re[j]);
            check($sformatf("%s_im[%0d]", nm, j), wq[j].im, 0);
            if (j < acc_q.size()) check($sformatf("%s_lat[%0d]", nm, j), wq[j].ed - acc_q[j], 4);
        end
    endtask

    task automatic end_frame(input bit en);
        Enable = en;
        FFTEnd = 1'b1;
        step();
        FFTEnd = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen [16];
        int uniq;
        int late;
        Reset = 1'b1; Enable = 1'b0; In_Valid = 1'b0; In_Sample = '0;
        FFTBusy = 1'b0; FFTEnd = 1'b0;
        repeat (3) step();
        Reset = 1'b0;
        check("rst_in_ready", int'(In_Ready), 0);
        check("rst_we", int'(WE), 0);
        check("rst_fft_start", int'(FFTStart), 0);
        check("rst_overrun", int'(Overrun), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_wr_addr", int'(WrRAMAddr), 0);
        check("rst_win_addr", int'(WinAddr), 0);
        check("rst_out_re", int'(Out_Re), 0);
        check("rst_out_im", int'(Out_Im), 0);

        // Scaling by 0.5 with Enable dropped right after frame start.
        for (int i = 0; i < 16; i++) begin samp[i] = 256; exp_re[i] = 128; end
        start_frame(1'b0);
        check_frame("scale");
        check("scale_start_count", fst_q.size(), 1);
        if (fst_q.size() > 0 && wq.size() > 0)
            check("scale_start_gap", fst_q[0] - wq[wq.size()-1].ed, 1);
        check("scale_wait_busy", int'(Busy), 1);
        end_frame(1'b1);
        check("scale_reload_ready", int'(In_Ready), 1);

        // Ramped window coefficients check ROM address alignment.
        rom_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin samp[i] = 256; exp_re[i] = 16 * i; end
        clear_log();
        run_frame(1'b0, 16);
        repeat (8) step();
        check_frame("ramp");
        end_frame(1'b0);
        check("ramp_idle_ready", int'(In_Ready), 0);
        check("ramp_idle_busy", int'(Busy), 0);
        FFTEnd = 1'b1;
        step();
        FFTEnd = 1'b0;
        step();
        check("idle_end_ignored", int'(Busy), 0);

        // Floor rounding of negative and extreme samples.
        rom_mode = 1'b0;
        for (int i = 0; i < 16; i++) begin samp[i] = rnd_s[i]; exp_re[i] = rnd_e[i]; end
        start_frame(1'b0);
        check_frame("round");
        if (wq.size() > 0) check("round_raw", wq[0].raw, 32'h3FFFE);
        end_frame(1'b0);

        // FFT core busy holds off the start pulse; input in WAIT flags overrun.
        for (int i = 0; i < 16; i++) begin samp[i] = 256; exp_re[i] = 128; end
        FFTBusy = 1'b1;
        start_frame(1'b0);
        repeat (10) step();
        check("bp_held_start", fst_q.size(), 0);
        check("bp_busy", int'(Busy), 1);
        check("bp_writes", wq.size(), 16);
        FFTBusy = 1'b0;
        step();
        step();
        check("bp_start_count", fst_q.size(), 1);
        if (fst_q.size() > 0 && wq.size() > 0)
            check("bp_start_late", int'(fst_q[0] - wq[wq.size()-1].ed > 10), 1);
        check("bp_overrun_clear", int'(Overrun), 0);
        In_Valid = 1'b1;
        step();
        In_Valid = 1'b0;
        step();
        check("bp_overrun_set", int'(Overrun), 1);
        end_frame(1'b0);
        check("bp_idle_ready", int'(In_Ready), 0);
        check("bp_idle_busy", int'(Busy), 0);
        check("bp_overrun_sticky", int'(Overrun), 1);

        // Gapped input: every other cycle valid.
        for (int i = 0; i < 16; i++) begin samp[i] = 32 * i; exp_re[i] = 16 * i; end
        start_frame(1'b1);
        repeat (20) step();
        check_frame("gap");
        for (int i = 0; i < 16; i++) seen[i] = 0;
        foreach (wq[j]) seen[wq[j].addr & 15]++;
        uniq = 0;
        for (int i = 0; i < 16; i++) if (seen[i] == 1) uniq++;
        check("gap_unique_addrs", uniq, 16);
        end_frame(1'b0);

        // Reset after 7 accepted samples discards the rest of the frame.
        for (int i = 0; i < 16; i++) begin samp[i] = 256; exp_re[i] = 128; end
        clear_log();
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        run_frame(1'b0, 7);
        Reset = 1'b1;
        late = cyc + 1;
        step();
        Reset = 1'b0;
        check("mid_rst_win_addr", int'(WinAddr), 0);
        check("mid_rst_ready", int'(In_Ready), 0);
        check("mid_rst_overrun", int'(Overrun), 0);
        check("mid_rst_busy", int'(Busy), 0);
        repeat (12) step();
        check("mid_rst_pre_writes", wq.size(), 3);
        uniq = 0;
        foreach (wq[j]) if (wq[j].ed >= late) uniq++;
        check("mid_rst_post_writes", uniq, 0);
        start_frame(1'b0);
        if (wq.size() > 0) check("mid_rst_first_addr", wq[0].addr, 0);
        check_frame("after_rst");
        end_frame(1'b0);

        check("zero_when_idle", zviol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
